bpu_ras: RTL
============

Name: bpu_ras

Overview:
- Second-generation branch prediction unit for the fetch stage.
- Combines a gshare pattern history table (PHT), a tagged direct-mapped BTB that records branch type, and a speculative return address stack (RAS).
- The RAS has a committed shadow copy, used to recover the speculative stack on flush.
- Prediction is combinational on the current PC. Updates come from the commit-stage resolution bus.

Parameters:
XLEN, 64, address width
HLEN, 4, global history length; PHT has 2^HLEN 2-bit counters
BTB_BITS, 4, BTB index bits; BTB has 2^BTB_BITS entries
RAS_DEPTH, 4, RAS entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  pipeline flush / misprediction recovery
curr_pc_i  in  XLEN  fetch PC
pred_accept_i  in  1  fetch consumed this cycle's prediction
comm_res_valid_i  in  1  commit resolution valid
comm_res_pc_i  in  XLEN  resolved branch PC
comm_res_target_i  in  XLEN  resolved target
comm_res_taken_i  in  1  resolved direction
comm_res_mispredict_i  in  1  prediction was wrong
comm_res_type_i  in  2  00 cond, 01 jump, 10 call, 11 ret
pred_pc_o  out  XLEN  equals curr_pc_i
pred_taken_o  out  1  predicted taken
pred_target_o  out  XLEN  predicted target, bits[1:0]=00
pred_type_o  out  2  type from BTB hit; 00 on miss

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - all PHT counters = 01 (weakly not-taken);
  - GHR = 0;
  - all BTB valid bits = 0;
  - both RAS pointers and counts = 0.
  - Resulting outputs: pred_taken_o=0, pred_target_o=0, pred_type_o=00. rst_i has priority over every other input.
- Prediction (zero latency, from registered state):
  - BTB index = curr_pc_i[BTB_BITS+1:2]; tag = curr_pc_i[XLEN-1:BTB_BITS+2]; hit = valid & tag match.
  - PHT index = curr_pc_i[HLEN+1:2] XOR GHR.
  - pred_taken_o = hit & (type==cond ? counter[1] : 1).
  - pred_target_o = RAS top if (hit & type==ret & spec RAS non-empty); otherwise {BTB target, 2'b00}.
- Speculative RAS, updated only when pred_accept_i=1 and hit:
  - call: push curr_pc_i+4;
  - ret: pop.
  - Push when full overwrites the oldest entry (circular wrap); count saturates at RAS_DEPTH.
  - Pop when empty is a no-op.
- Committed RAS: on comm_res_valid_i with type call, push comm_res_pc_i+4; with type ret, pop. Same full/empty rules as the speculative RAS.
- flush_i: speculative RAS (entries, top pointer, count) is overwritten by the committed RAS.
  - If a commit occurs in the same cycle, the speculative RAS receives the post-commit committed state.
  - A flush suppresses that cycle's speculative push/pop.
  - PHT, BTB and GHR are not cleared by flush.
- Commit update, on comm_res_valid_i:
  - cond: PHT[comm_res_pc_i[HLEN+1:2] XOR GHR] saturating ±1 (00..11) by taken; GHR <= {GHR[HLEN-2:0], taken}.
  - BTB write (valid, tag, target[XLEN-1:2], type) when mispredict & taken.
  - BTB invalidate at the index of comm_res_pc_i when mispredict & ~taken.
  - Non-cond types do not touch PHT or GHR.
- Simultaneous BTB write and lookup at the same index: the lookup sees the old contents; the new contents are visible the next cycle.

Optional Feature:
- Macro: BPU_RAS_EN.
- Defined: both RAS copies and the ret-target override are present, as described above.
- Undefined:
  - no RAS storage;
  - RAS_DEPTH is ignored;
  - ret predicts the BTB target;
  - pred_accept_i and flush_i have no effect.

Test Plan (XLEN=64, HLEN=4, BTB_BITS=4, RAS_DEPTH=4, BPU_RAS_EN defined):
- Reset, curr_pc_i=0x1000 -> pred_taken_o=0, pred_target_o=0, pred_type_o=00, pred_pc_o=0x1000.
- Commit jump, pc=0x1000, target=0x2000, taken=1, mispredict=1; next cycle curr_pc_i=0x1000 -> taken=1, target=0x2000, type=01. Then commit pc=0x1000, taken=0, mispredict=1 -> next cycle taken=0.
- PHT/GHR check, from reset:
  - commit cond pc=0x1000, target=0x3000, taken=1, mispredict=1 -> PHT[0]=10, GHR=0001.
  - curr_pc_i=0x1004 gives index 1 XOR 1=0, but the BTB misses -> taken=0.
  - curr_pc_i=0x1000 gives index 1, counter 01 -> taken=0, target=0x3000.
- RAS: BTB holds call@0x1000->0x4000 and ret@0x4010.
  - Accept call at 0x1000, then curr_pc_i=0x4010 -> target=0x1004.
  - Accept ret -> RAS empty, so the next 0x4010 prediction returns the BTB ret target.
- Overflow: BTB calls at 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, all accepted (5 pushes).
  - Four accepted rets yield 0x1014, 0x1010, 0x100C, 0x1008.
  - The fifth ret yields the BTB target.
- Flush: accept call at 0x1000 (uncommitted), assert flush_i -> ret at 0x4010 predicts the BTB target.
  - Repeat with commit of call pc=0x1000 in the flush cycle -> ret predicts 0x1004.

Source files
------------

// File: rtl/bpu_ras_if.sv
// Fetch/commit bus of the branch prediction unit: fetch PC, prediction results,
// flush and the commit-stage resolution fields.
interface bpu_ras_if #(
    parameter int XLEN = 64
);
    logic            flush_i;
    logic [XLEN-1:0] curr_pc_i;
    logic            pred_accept_i;
    logic            comm_res_valid_i;
    logic [XLEN-1:0] comm_res_pc_i;
    logic [XLEN-1:0] comm_res_target_i;
    logic            comm_res_taken_i;
    logic            comm_res_mispredict_i;
    logic [1:0]      comm_res_type_i;
    logic [XLEN-1:0] pred_pc_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic [1:0]      pred_type_o;

    modport master (
        output flush_i, curr_pc_i, pred_accept_i,
        output comm_res_valid_i, comm_res_pc_i, comm_res_target_i,
        output comm_res_taken_i, comm_res_mispredict_i, comm_res_type_i,
        input  pred_pc_o, pred_taken_o, pred_target_o, pred_type_o
    );

    modport slave (
        input  flush_i, curr_pc_i, pred_accept_i,
        input  comm_res_valid_i, comm_res_pc_i, comm_res_target_i,
        input  comm_res_taken_i, comm_res_mispredict_i, comm_res_type_i,
        output pred_pc_o, pred_taken_o, pred_target_o, pred_type_o
    );
endinterface

// File: rtl/bpu_ras.sv
// Branch prediction unit: gshare PHT, tagged direct-mapped BTB with branch type and,
// when BPU_RAS_EN is defined, a speculative return address stack with a committed shadow.
module bpu_ras #(
    parameter int XLEN      = 64,
    parameter int HLEN      = 4,
    parameter int BTB_BITS  = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    bpu_ras_if.slave bus
);
    localparam int PHT_N = 1 << HLEN;
    localparam int BTB_N = 1 << BTB_BITS;
    localparam int TAG_W = XLEN - BTB_BITS - 2;
    localparam int TGT_W = XLEN - 2;

    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

    function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11)
            r = c + 2'b01;
        else if (!up && c != 2'b00)
            r = c - 2'b01;
        return r;
    endfunction

    logic [PHT_N-1:0][1:0]       pht_q, pht_d;
    logic [HLEN-1:0]             ghr_q, ghr_d;
    logic [BTB_N-1:0]            btb_vld_q, btb_vld_d;
    logic [BTB_N-1:0][TAG_W-1:0] btb_tag_q, btb_tag_d;
    logic [BTB_N-1:0][TGT_W-1:0] btb_tgt_q, btb_tgt_d;
    logic [BTB_N-1:0][1:0]       btb_typ_q, btb_typ_d;

    logic [BTB_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [HLEN-1:0]     lk_pht_idx;
    logic                lk_hit;
    logic [1:0]          lk_typ;

    logic [BTB_BITS-1:0] cm_idx;
    logic [HLEN-1:0]     cm_pht_idx;

    // Lookup always reads registered state, so a same-cycle commit write is seen next cycle.
    always_comb begin
        lk_idx     = bus.curr_pc_i[BTB_BITS+1:2];
        lk_tag     = bus.curr_pc_i[XLEN-1:BTB_BITS+2];
        lk_pht_idx = bus.curr_pc_i[HLEN+1:2] ^ ghr_q;
        lk_hit     = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        lk_typ     = btb_typ_q[lk_idx];
    end

    always_comb begin
        pht_d      = pht_q;
        ghr_d      = ghr_q;
        btb_vld_d  = btb_vld_q;
        btb_tag_d  = btb_tag_q;
        btb_tgt_d  = btb_tgt_q;
        btb_typ_d  = btb_typ_q;
        cm_idx     = bus.comm_res_pc_i[BTB_BITS+1:2];
        cm_pht_idx = bus.comm_res_pc_i[HLEN+1:2] ^ ghr_q;
        if (bus.comm_res_valid_i) begin
            if (bus.comm_res_type_i == T_COND) begin
                pht_d[cm_pht_idx] = sat_cnt(pht_q[cm_pht_idx], bus.comm_res_taken_i);
                ghr_d             = {ghr_q[HLEN-2:0], bus.comm_res_taken_i};
            end
            if (bus.comm_res_mispredict_i) begin
                if (bus.comm_res_taken_i) begin
                    btb_vld_d[cm_idx] = 1'b1;
                    btb_tag_d[cm_idx] = bus.comm_res_pc_i[XLEN-1:BTB_BITS+2];
                    btb_tgt_d[cm_idx] = bus.comm_res_target_i[XLEN-1:2];
                    btb_typ_d[cm_idx] = bus.comm_res_type_i;
                end else begin
                    btb_vld_d[cm_idx] = 1'b0;
                end
            end
        end
    end

    // Targets are cleared on reset so a miss right after reset predicts address 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pht_q     <= {PHT_N{2'b01}};
            ghr_q     <= '0;
            btb_vld_q <= '0;
            btb_tgt_q <= '0;
        end else begin
            pht_q     <= pht_d;
            ghr_q     <= ghr_d;
            btb_vld_q <= btb_vld_d;
            btb_tgt_q <= btb_tgt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        btb_tag_q <= btb_tag_d;
        btb_typ_q <= btb_typ_d;
    end

`ifdef BPU_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    // ptr addresses the next free slot; the top of stack sits at ptr-1 (circular).
    typedef struct packed {
        logic [RAS_DEPTH-1:0][XLEN-1:0] ent;
        logic [PW-1:0]                  ptr;
        logic [CW-1:0]                  cnt;
    } ras_t;

    function automatic ras_t ras_push(input ras_t r, input logic [XLEN-1:0] v);
        ras_t n;
        n            = r;
        n.ent[r.ptr] = v;
        n.ptr        = r.ptr + PW'(1);
        if (r.cnt != RAS_FULL)
            n.cnt = r.cnt + CW'(1);
        return n;
    endfunction

    function automatic ras_t ras_pop(input ras_t r);
        ras_t n;
        n = r;
        if (r.cnt != '0) begin
            n.ptr = r.ptr - PW'(1);
            n.cnt = r.cnt - CW'(1);
        end
        return n;
    endfunction

    ras_t            com_q, com_d;
    ras_t            spec_q, spec_d;
    logic            ras_top_vld;
    logic [XLEN-1:0] ras_top;

    // The committed copy updates first so a flush in the same cycle picks up its result.
    always_comb begin
        com_d = com_q;
        if (bus.comm_res_valid_i) begin
            if (bus.comm_res_type_i == T_CALL)
                com_d = ras_push(com_q, bus.comm_res_pc_i + XLEN'(4));
            else if (bus.comm_res_type_i == T_RET)
                com_d = ras_pop(com_q);
        end
        spec_d = spec_q;
        if (bus.flush_i) begin
            spec_d = com_d;
        end else if (bus.pred_accept_i && lk_hit) begin
            if (lk_typ == T_CALL)
                spec_d = ras_push(spec_q, bus.curr_pc_i + XLEN'(4));
            else if (lk_typ == T_RET)
                spec_d = ras_pop(spec_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            com_q.ptr  <= '0;
            com_q.cnt  <= '0;
            spec_q.ptr <= '0;
            spec_q.cnt <= '0;
        end else begin
            com_q  <= com_d;
            spec_q <= spec_d;
        end
    end

    always_comb begin
        ras_top_vld = (spec_q.cnt != '0);
        ras_top     = spec_q.ent[spec_q.ptr - PW'(1)];
    end
`endif

    always_comb begin
        bus.pred_pc_o     = bus.curr_pc_i;
        bus.pred_type_o   = lk_hit ? lk_typ : 2'b00;
        bus.pred_taken_o  = lk_hit && ((lk_typ == T_COND) ? pht_q[lk_pht_idx][1] : 1'b1);
        bus.pred_target_o = {btb_tgt_q[lk_idx], 2'b00};
`ifdef BPU_RAS_EN
        if (lk_hit && lk_typ == T_RET && ras_top_vld)
            bus.pred_target_o = ras_top & ~XLEN'(3);
`endif
    end

    // Byte-offset bits never select anything; flush/accept only matter with the stack present.
    logic unused_ok;
    assign unused_ok = ^{bus.curr_pc_i[1:0], bus.comm_res_pc_i[1:0], bus.comm_res_target_i[1:0],
                         bus.flush_i, bus.pred_accept_i};

endmodule
